// File: rtl/ariane_pkg.sv
// Shared L1 data-cache geometry constants used by the dcache blocks.
package ariane_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_BYTE_OFFSET = 4;
  localparam int unsigned DCACHE_SET_ASSOC   = 8;
  localparam int unsigned DCACHE_NUM_WORDS   = 2 ** (DCACHE_INDEX_WIDTH - DCACHE_BYTE_OFFSET);

endpackage : ariane_pkg

// File: rtl/std_cache_pkg.sv
// Types and constants shared by the standard write-back dcache blocks.
package std_cache_pkg;

  // Invalidate sequencer states; LINE is only reachable with single-line
  // invalidation enabled.
  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    WALK,
    DONE,
    LINE
  } inval_state_e;

  // Width of the valid/dirty byte-enable vector: 8 byte lanes per way.
  localparam int unsigned DCACHE_VLDRTY_BE_W = ariane_pkg::DCACHE_SET_ASSOC * 8;

endpackage : std_cache_pkg

// File: rtl/dcache_inval_seq.sv
// dcache_inval_seq: clears valid/dirty of every dcache set by walking the
// index space through the SRAM arbiter. Runs after reset (init_ni low) and
// on a full-invalidate request, stalling the cache controllers meanwhile.
// Optional single-line invalidation: define DCACHE_INVAL_SINGLE_EN.
module dcache_inval_seq
  import std_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = ariane_pkg::DCACHE_NUM_WORDS,
  parameter int unsigned INDEX_W     = ariane_pkg::DCACHE_INDEX_WIDTH,
  parameter int unsigned BYTE_OFFSET = ariane_pkg::DCACHE_BYTE_OFFSET,
  parameter int unsigned SET_ASSOC   = ariane_pkg::DCACHE_SET_ASSOC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   init_ni,
  input  logic                   inval_req_i,
  output logic                   inval_ack_o,
  input  logic                   busy_i,
  output logic                   stall_o,
  output logic                   busy_o,
  output logic [SET_ASSOC-1:0]   req_o,
  output logic [INDEX_W-1:0]     addr_o,
  output logic                   we_o,
  output logic [SET_ASSOC*8-1:0] be_vldrty_o,
`ifdef DCACHE_INVAL_SINGLE_EN
  input  logic                   line_req_i,
  input  logic [INDEX_W-1:0]     line_addr_i,
  output logic                   line_ack_o,
`endif
  input  logic                   gnt_i
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

  inval_state_e              state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          idx_d;
  logic                      pend_q;
  logic                      rst_rel_q;   // high only in the first cycle after reset release
  logic                      ack_q;
  logic                      stall_q;
  logic                      busy_q;
  logic [SET_ASSOC-1:0]      req_q;
  logic                      we_q;
  logic [SET_ASSOC*8-1:0]    be_q;
  logic [INDEX_W-1:0]        addr_q;
  logic                      take_req;    // full request may be latched into pend this cycle

`ifdef DCACHE_INVAL_SINGLE_EN
  logic                      line_q;
  logic [IDX_W-1:0]          line_idx_q;
  logic                      line_ack_q;
`endif

  // Next walk index and whether a full request may be recorded as pending.
  // NOTE: every signal driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    idx_d    = idx_q + IDX_W'(1);
    take_req = inval_req_i;
`ifdef DCACHE_INVAL_SINGLE_EN
    // A full request arriving during a line operation waits in IDLE instead.
    take_req = inval_req_i && !line_q;
`endif
  end

  // Sequencer FSM with registered outputs; the index counter lives here too.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      rst_rel_q <= 1'b1;
      ack_q     <= 1'b0;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
`ifdef DCACHE_INVAL_SINGLE_EN
      line_q     <= 1'b0;
      line_idx_q <= '0;
      line_ack_q <= 1'b0;
`endif
    end else begin
      rst_rel_q <= 1'b0;
      ack_q     <= 1'b0;
`ifdef DCACHE_INVAL_SINGLE_EN
      line_ack_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (inval_req_i || (rst_rel_q && !init_ni)) begin
            state_q <= QUIESCE;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
            pend_q  <= inval_req_i;
          end
`ifdef DCACHE_INVAL_SINGLE_EN
          else if (line_req_i) begin
            state_q    <= QUIESCE;
            stall_q    <= 1'b1;
            busy_q     <= 1'b1;
            line_q     <= 1'b1;
            line_idx_q <= line_addr_i[INDEX_W-1:BYTE_OFFSET];
          end
`endif
        end

        QUIESCE: begin
          if (take_req) pend_q <= 1'b1;
          if (!busy_i) begin
            req_q <= '1;
            we_q  <= 1'b1;
            be_q  <= '1;
`ifdef DCACHE_INVAL_SINGLE_EN
            if (line_q) begin
              state_q <= LINE;
              addr_q  <= INDEX_W'({line_idx_q, {BYTE_OFFSET{1'b0}}});
            end else
`endif
            begin
              state_q <= WALK;
              addr_q  <= INDEX_W'({idx_q, {BYTE_OFFSET{1'b0}}});
            end
          end
        end

        WALK: begin
          if (inval_req_i) pend_q <= 1'b1;
          // Terminal compare precedes the increment, so idx never wraps.
          if (gnt_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              req_q   <= '0;
              we_q    <= 1'b0;
              be_q    <= '0;
              addr_q  <= '0;
              idx_q   <= '0;
              // A request landing on the final grant is covered by this walk.
              ack_q   <= pend_q || inval_req_i;
            end else begin
              idx_q  <= idx_d;
              addr_q <= INDEX_W'({idx_d, {BYTE_OFFSET{1'b0}}});
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          pend_q  <= 1'b0;
        end

        LINE: begin
`ifdef DCACHE_INVAL_SINGLE_EN
          if (gnt_i) begin
            state_q    <= IDLE;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
            req_q      <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            line_q     <= 1'b0;
            line_ack_q <= 1'b1;
          end
`else
          state_q <= IDLE;
`endif
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign inval_ack_o = ack_q;
  assign stall_o     = stall_q;
  assign busy_o      = busy_q;
  assign req_o       = req_q;
  assign addr_o      = addr_q;
  assign we_o        = we_q;
  assign be_vldrty_o = be_q;
`ifdef DCACHE_INVAL_SINGLE_EN
  assign line_ack_o  = line_ack_q;
`endif

endmodule : dcache_inval_seq

// File: tb/tb_dcache_inval_seq.sv
// Self-checking bench for dcache_inval_seq: a flag-level model of the
// invalidate protocol checked every cycle, plus directed literal checks.
module tb_dcache_inval_seq;

  localparam int NUM_SETS = 256;
  localparam int INDEX_W  = 12;
  localparam int SA       = 8;

  logic                clk = 1'b0;
  logic                rst_i, init_ni, inval_req_i, busy_i, gnt_i;
  logic                inval_ack_o, stall_o, busy_o, we_o;
  logic [SA-1:0]       req_o;
  logic [INDEX_W-1:0]  addr_o;
  logic [SA*8-1:0]     be_vldrty_o;
`ifdef DCACHE_INVAL_SINGLE_EN
  logic                line_req_i, line_ack_o;
  logic [INDEX_W-1:0]  line_addr_i;
`endif

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  cmp_en = 1'b0;

  // Model state: request/walk bookkeeping in protocol terms.
  bit  m_active, m_walk, m_last, m_pend, m_first;
  int  m_grants;

  dcache_inval_seq dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .init_ni     (init_ni),
    .inval_req_i (inval_req_i),
    .inval_ack_o (inval_ack_o),
    .busy_i      (busy_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .req_o       (req_o),
    .addr_o      (addr_o),
    .we_o        (we_o),
    .be_vldrty_o (be_vldrty_o),
`ifdef DCACHE_INVAL_SINGLE_EN
    .line_req_i  (line_req_i),
    .line_addr_i (line_addr_i),
    .line_ack_o  (line_ack_o),
`endif
    .gnt_i       (gnt_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Protocol model: a request (or init after reset) activates the sequencer,
  // the walk starts once busy_i is seen low, NUM_SETS grants finish it, and
  // the cycle after the last grant acks if any full request was seen.
  always @(posedge clk) begin
    if (rst_i) begin
      m_active = 0; m_walk = 0; m_last = 0; m_pend = 0; m_first = 1; m_grants = 0;
    end else begin
      if (m_last) begin
        m_active = 0; m_pend = 0; m_last = 0;
      end else if (!m_active) begin
        if (inval_req_i) begin m_active = 1; m_pend = 1; end
        if (m_first && !init_ni) m_active = 1;
      end else begin
        if (inval_req_i) m_pend = 1;
        if (!m_walk) begin
          if (!busy_i) m_walk = 1;
        end else if (gnt_i) begin
          m_grants++;
          if (m_grants == NUM_SETS) begin
            m_grants = 0; m_walk = 0; m_last = 1;
          end
        end
      end
      m_first = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall", stall_o, m_active);
      check("busy", busy_o, m_active);
      check("req", req_o, m_walk ? {SA{1'b1}} : '0);
      check("we", we_o, m_walk);
      check("be", be_vldrty_o, m_walk ? {SA*8{1'b1}} : '0);
      check("ack", inval_ack_o, m_last && m_pend);
      if (m_walk) check("addr", addr_o, 64'(m_grants * 16));
    end
  end

  int  wr_cnt [NUM_SETS];
  int  n, grants, bad;
  bit  got;

  initial begin
    rst_i = 1; init_ni = 1; inval_req_i = 0; busy_i = 0; gnt_i = 1;
`ifdef DCACHE_INVAL_SINGLE_EN
    line_req_i = 0; line_addr_i = '0;
`endif
    tick(); tick();
    cmp_en = 1;
    check("rst_req", req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_be", be_vldrty_o, 0);

    // init_ni high: no walk after reset
    rst_i = 0;
    repeat (5) begin tick(); check("noinit_busy", busy_o, 0); end

    // init walk after reset, gnt tied high
    rst_i = 1; init_ni = 0; tick(); rst_i = 0;
    tick(); check("init_stall_c1", stall_o, 1); check("init_req_c1", req_o, 0);
    tick(); check("init_req_c2", req_o, 8'hFF); check("init_addr_c2", addr_o, 12'h000);
    for (int c = 3; c <= 259; c++) begin
      tick();
      if (c == 257) check("init_addr_last", addr_o, 12'hFF0);
      if (c == 258) begin check("init_busy_done", busy_o, 1); check("init_no_ack", inval_ack_o, 0); end
      if (c == 259) check("init_busy_c259", busy_o, 0);
    end

    // request while controllers busy for 5 cycles
    busy_i = 1; inval_req_i = 1;
    tick(); check("q_stall", stall_o, 1); check("q_req0", req_o, 0);
    repeat (4) begin tick(); check("q_req_hold0", req_o, 0); end
    busy_i = 0;
    tick(); check("q_walk_start", req_o, 8'hFF); check("q_walk_addr", addr_o, 0);
    n = 0; got = 0;
    while (!got && n < 400) begin tick(); n++; if (inval_ack_o) got = 1; end
    check("q_ack_seen", got, 1);
    check("q_ack_latency", n, 256);
    inval_req_i = 0;
    tick(); check("q_ack_pulse", inval_ack_o, 0); check("q_idle", busy_o, 0);

    // pseudo-random grants: each index written exactly once
    for (int i = 0; i < NUM_SETS; i++) wr_cnt[i] = 0;
    inval_req_i = 1; grants = 0; got = 0; n = 0;
    while (!got && n < 3000) begin
      gnt_i = 1'($urandom_range(0, 1));
      if (req_o != 0 && gnt_i) begin grants++; wr_cnt[addr_o[11:4]]++; end
      tick(); n++;
      if (inval_ack_o) got = 1;
    end
    inval_req_i = 0; gnt_i = 1;
    check("rg_ack_seen", got, 1);
    check("rg_grants", grants, 256);
    bad = 0;
    for (int i = 0; i < NUM_SETS; i++) if (wr_cnt[i] != 1) bad++;
    check("rg_each_once", bad, 0);
    tick(); check("rg_idle", busy_o, 0);

    // request during init walk at idx 100: one walk, acked at its end
    rst_i = 1; tick(); rst_i = 0;
    n = 0; got = 0;
    while (!got && n < 400) begin tick(); n++; if (req_o != 0 && addr_o == 12'h640) got = 1; end
    check("mid_reach_idx100", got, 1);
    inval_req_i = 1;
    n = 0; got = 0;
    while (!got && n < 400) begin tick(); n++; if (inval_ack_o) got = 1; end
    check("mid_ack_seen", got, 1);
    check("mid_ack_latency", n, 156);
    inval_req_i = 0;
    repeat (10) begin tick(); check("mid_no_rewalk", req_o, 0); end

    // reset at idx 37: outputs cleared, walk restarts from 0
    rst_i = 1; tick(); rst_i = 0;
    n = 0; got = 0;
    while (!got && n < 400) begin tick(); n++; if (req_o != 0 && addr_o == 12'h250) got = 1; end
    check("rst37_reach", got, 1);
    rst_i = 1; tick();
    check("rst37_req", req_o, 0); check("rst37_we", we_o, 0); check("rst37_stall", stall_o, 0);
    check("rst37_busy", busy_o, 0); check("rst37_addr", addr_o, 0); check("rst37_be", be_vldrty_o, 0);
    rst_i = 0;
    tick(); check("rst37_restart_stall", stall_o, 1);
    tick(); check("rst37_restart_req", req_o, 8'hFF); check("rst37_restart_addr", addr_o, 0);
    n = 0;
    while (busy_o && n < 400) begin tick(); n++; end
    check("rst37_walk_done", busy_o, 0);

`ifdef DCACHE_INVAL_SINGLE_EN
    // single-line invalidate at 0x5A0
    cmp_en = 0;
    line_addr_i = 12'h5A0; line_req_i = 1; gnt_i = 0;
    n = 0;
    while (req_o == 0 && n < 20) begin tick(); n++; end
    check("line_req", req_o, 8'hFF);
    check("line_addr", addr_o, 12'h5A0);
    tick(); check("line_addr_hold", addr_o, 12'h5A0); check("line_no_ack", line_ack_o, 0);
    gnt_i = 1;
    tick(); check("line_ack", line_ack_o, 1); check("line_req_done", req_o, 0);
    line_req_i = 0;
    tick(); check("line_ack_pulse", line_ack_o, 0); check("line_idle", busy_o, 0);
`endif

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_dcache_inval_seq
